axis_pkt_fifo: RTL

Store-and-forward AXI-Stream packet FIFO that sits directly upstream of the stream-processing stage driven by our AXI master/slave models. It accepts tlast-delimited packets on its slave port and presents a packet on its master port only after the whole packet has been written. Packets that cannot fit are dropped whole and counted, so downstream never sees a truncated packet.

---
 rtl/axis_pkt_fifo.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: packets become visible downstream only
// once their tlast is stored; packets that overflow the RAM are dropped whole and counted.
module axis_pkt_fifo #(
  parameter int TDATA_WIDTH = 32,
  parameter int TUSER_WIDTH = 8,
  parameter int DEPTH       = 64,
  parameter int CNT_WIDTH   = 16,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [CNT_WIDTH-1:0]   pkt_count,
  output logic [CNT_WIDTH-1:0]   drop_count,
  output logic [ADDR_W:0]        level
);

  localparam int PTR_W  = ADDR_W + 1;
  localparam int WORD_W = TDATA_WIDTH + TUSER_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   wr_commit_q, wr_commit_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  logic [WORD_W-1:0]  m_word_q, m_word_d;
  logic               m_valid_q, m_valid_d;
  logic               s_ready_q;

  logic in_acc, full, load, pop_last;
  logic wr_en, rewind, commit, drop_inc;

  assign in_acc   = s_axis_tvalid && s_ready_q;
  assign full     = (wr_ptr_q - rd_ptr_q) == PTR_W'(DEPTH);
  // Only words behind wr_commit are readable, so partial packets never leak out.
  assign load     = (rd_ptr_q != wr_commit_q) && (!m_valid_q || m_axis_tready);
  assign pop_last = m_valid_q && m_axis_tready && m_word_q[WORD_W-1];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (in_acc) begin
      case (state_q)
        S_IDLE, S_WRITE: begin
          if (s_axis_tlast) state_d = S_IDLE;
          else              state_d = full ? S_DROP : S_WRITE;
        end
        S_DROP:  if (s_axis_tlast) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    rewind   = 1'b0;
    commit   = 1'b0;
    drop_inc = 1'b0;
    if (in_acc && state_q != S_DROP) begin
      if (!full) begin
        wr_en  = 1'b1;
        commit = s_axis_tlast;
      end else begin
        rewind   = 1'b1;
        drop_inc = 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    if (rewind)     wr_ptr_d = wr_commit_q;
    else if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    wr_commit_d = commit ? wr_ptr_q + PTR_W'(1) : wr_commit_q;
    rd_ptr_d    = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    pkt_d = pkt_q;
    if (commit && !pop_last)      pkt_d = pkt_q + CNT_WIDTH'(1);
    else if (!commit && pop_last) pkt_d = pkt_q - CNT_WIDTH'(1);
    drop_d = (drop_inc && drop_q != '1) ? drop_q + CNT_WIDTH'(1) : drop_q;

    m_valid_d = m_valid_q;
    m_word_d  = m_word_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_word_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
    end else if (m_axis_tready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      pkt_q       <= '0;
      drop_q      <= '0;
      m_word_q    <= '0;
      m_valid_q   <= 1'b0;
      s_ready_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_q       <= pkt_d;
      drop_q      <= drop_d;
      m_word_q    <= m_word_d;
      m_valid_q   <= m_valid_d;
      s_ready_q   <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tdata};
  end

  assign s_axis_tready = s_ready_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tdata  = m_word_q[TDATA_WIDTH-1:0];
  assign m_axis_tuser  = m_word_q[TDATA_WIDTH +: TUSER_WIDTH];
  assign m_axis_tlast  = m_word_q[WORD_W-1];
  assign pkt_count     = pkt_q;
  assign drop_count    = drop_q;
  assign level         = wr_ptr_q - rd_ptr_q;

endmodule
